// File: rtl/mem_access_unit.sv
// Memory-access stage: drives a sync RAM with RD_LAT read latency and loads MDR.
// Define BOUND_CHECK_EN to enable the sticky out-of-range fault against MEM_DEPTH.
module mem_access_unit #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int MEM_DEPTH = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic              sel_ext,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic [DATA_W-1:0] ext_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] mdr,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, FIN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d, mdr_d;
   logic              wren_d;
   logic              oob;

   if (RD_LAT < 1 || RD_LAT > 15 || MEM_DEPTH < 1) begin : g_bad_param
      $error("mem_access_unit: illegal RD_LAT or MEM_DEPTH");
   end

`ifdef BOUND_CHECK_EN
   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

   assign oob = ({1'b0, addr_in} >= DEPTH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         fault <= 1'b0;
      else if (state_q == IDLE && start && oob)
         fault <= 1'b1;
   end
`else
   assign oob   = 1'b0;
   assign fault = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      wren_d  = 1'b0;
      mdr_d   = mdr;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = sel_ext;
               state_d = FIN;
               // Out-of-range commands skip the RAM and MDR entirely.
               if (oob) begin
                  state_d = FIN;
               end else if (rd_req) begin
                  addr_d  = addr_in;
                  cnt_d   = 4'(RD_LAT);
                  state_d = RD_WAIT;
               end else if (wr_req) begin
                  addr_d  = addr_in;
                  wdata_d = wdata_in;
                  wren_d  = 1'b1;
                  state_d = WR;
               end else begin
                  wdata_d = '0;
                  if (sel_ext)
                     mdr_d = ext_in;
               end
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               mdr_d   = sel_q ? ext_in : mem_rdata;
               state_d = FIN;
            end
         end
         WR: begin
            if (sel_q)
               mdr_d = ext_in;
            state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wren  <= 1'b0;
         mdr       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         mem_wren  <= wren_d;
         mdr       <= mdr_d;
         busy      <= (state_d != IDLE);
         done      <= (state_d == FIN);
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RD_LAT=1 and RD_LAT=3 instances share one stimulus
// stream; a per-instance scoreboard checks MDR, latency and fault at each done.
module tb_mem_access_unit;

   localparam int L0 = 1;
   localparam int L1 = 3;

   typedef struct {
      logic [15:0] mdr;
      logic        flt;
      int          c0;
      int          lat;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, start, rd_req, wr_req, sel_ext;
   logic [15:0] addr_in, wdata_in, ext_in;
   logic [15:0] mem_addr [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];
   logic [15:0] mdr [2];
   logic        mem_wren [2];
   logic        busy [2];
   logic        done [2];
   logic        fault [2];

   logic [15:0] ram0 [0:65535];
   logic [15:0] ram1 [0:65535];
   logic [15:0] ad1, ad2;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t e0, e1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic flt_exp = 1'b0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   mem_access_unit #(
      .DATA_W(16), .ADDR_W(16), .RD_LAT(L0), .MEM_DEPTH(4096)
   ) u_lat1 (
      .clock(clock), .reset(reset), .start(start),
      .rd_req(rd_req), .wr_req(wr_req), .sel_ext(sel_ext),
      .addr_in(addr_in), .wdata_in(wdata_in), .ext_in(ext_in),
      .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_wren(mem_wren[0]), .mem_rdata(mem_rdata[0]),
      .mdr(mdr[0]), .busy(busy[0]), .done(done[0]), .fault(fault[0])
   );

   mem_access_unit #(
      .DATA_W(16), .ADDR_W(16), .RD_LAT(L1), .MEM_DEPTH(4096)
   ) u_lat3 (
      .clock(clock), .reset(reset), .start(start),
      .rd_req(rd_req), .wr_req(wr_req), .sel_ext(sel_ext),
      .addr_in(addr_in), .wdata_in(wdata_in), .ext_in(ext_in),
      .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_wren(mem_wren[1]), .mem_rdata(mem_rdata[1]),
      .mdr(mdr[1]), .busy(busy[1]), .done(done[1]), .fault(fault[1])
   );

   // RAM models: q valid RD_LAT edges after the address is registered.
   always @(posedge clock) begin
      if (reset) begin
         ram0[16'h0005] <= 16'hBEEF;
         ram0[16'h0020] <= 16'h5A5A;
         ram0[16'h0FFF] <= 16'hCAFE;
      end else if (mem_wren[0]) begin
         ram0[mem_addr[0]] <= mem_wdata[0];
      end
   end

   always @(posedge clock) begin
      ad1 <= mem_addr[1];
      ad2 <= ad1;
      if (reset) begin
         ram1[16'h0005] <= 16'hBEEF;
         ram1[16'h0020] <= 16'h5A5A;
         ram1[16'h0FFF] <= 16'hCAFE;
      end else if (mem_wren[1]) begin
         ram1[mem_addr[1]] <= mem_wdata[1];
      end
   end

   assign mem_rdata[0] = ram0[mem_addr[0]];
   assign mem_rdata[1] = ram1[ad2];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && done[0]) begin
         if (sb0.size() == 0) begin
            check("lat1_extra_done", 32'd1, 32'd0);
         end else begin
            e0 = sb0.pop_front();
            check("lat1_mdr", 32'(mdr[0]), 32'(e0.mdr));
            check("lat1_latency", cyc - e0.c0 + 1, e0.lat);
            check("lat1_fault", 32'(fault[0]), 32'(e0.flt));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && done[1]) begin
         if (sb1.size() == 0) begin
            check("lat3_extra_done", 32'd1, 32'd0);
         end else begin
            e1 = sb1.pop_front();
            check("lat3_mdr", 32'(mdr[1]), 32'(e1.mdr));
            check("lat3_latency", cyc - e1.c0 + 1, e1.lat);
            check("lat3_fault", 32'(fault[1]), 32'(e1.flt));
         end
      end
   end

   task automatic issue(input string tag, input logic rd, input logic wr,
                        input logic sel, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] ex,
                        input logic [15:0] want_mdr, input logic rs);
      logic oob;
      int   lat [2];
      int   bc [2];
      int   nw [2];
      int   k;
      int   to;
      exp_t e;
      oob = 1'b0;
`ifdef BOUND_CHECK_EN
      oob = (a >= 16'h1000);
`endif
      if (oob)
         flt_exp = 1'b1;
      lat[0] = oob ? 1 : rd ? L0 + 1 : wr ? 2 : 1;
      lat[1] = oob ? 1 : rd ? L1 + 1 : wr ? 2 : 1;
      @(negedge clock);
      rd_req   = rd;
      wr_req   = wr;
      sel_ext  = sel;
      addr_in  = a;
      wdata_in = wd;
      ext_in   = ex;
      start    = 1'b1;
      e.mdr = want_mdr;
      e.flt = flt_exp;
      e.c0  = cyc + 1;
      e.lat = lat[0];
      sb0.push_back(e);
      e.lat = lat[1];
      sb1.push_back(e);
      @(negedge clock);
      // Optional second strobe while busy; it must be dropped.
      start    = rs;
      rd_req   = rs;
      wr_req   = 1'b0;
      sel_ext  = 1'b0;
      addr_in  = ~a;
      wdata_in = ~wd;
      for (int i = 0; i < 2; i++) begin
         bc[i] = 0;
         nw[i] = 0;
      end
      k = 0;
      while ((busy[0] || busy[1]) && k < 40) begin
         for (int i = 0; i < 2; i++) begin
            if (busy[i]) bc[i]++;
            if (mem_wren[i]) nw[i]++;
         end
         @(negedge clock);
         start  = 1'b0;
         rd_req = 1'b0;
         k++;
      end
      start  = 1'b0;
      rd_req = 1'b0;
      to = (k >= 40) ? 1 : 0;
      check($sformatf("%s_timeout", tag), to, 0);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_busy_cycles%0d", tag, i), bc[i], lat[i]);
         check($sformatf("%s_wren_cycles%0d", tag, i), nw[i],
               (wr && !rd && !oob) ? 1 : 0);
         check($sformatf("%s_fault%0d", tag, i), 32'(fault[i]), 32'(flt_exp));
         if ((rd || wr) && !oob)
            check($sformatf("%s_mem_addr%0d", tag, i), 32'(mem_addr[i]), 32'(a));
      end
      @(negedge clock);
      for (int i = 0; i < 2; i++)
         check($sformatf("%s_idle_after%0d", tag, i), 32'(busy[i]), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      sel_ext  = 1'b0;
      addr_in  = '0;
      wdata_in = '0;
      ext_in   = '0;
      repeat (3) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_mdr%0d", i), 32'(mdr[i]), 32'd0);
         check($sformatf("rst_addr%0d", i), 32'(mem_addr[i]), 32'd0);
         check($sformatf("rst_wdata%0d", i), 32'(mem_wdata[i]), 32'd0);
         check($sformatf("rst_wren%0d", i), 32'(mem_wren[i]), 32'd0);
         check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
         check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
         check($sformatf("rst_fault%0d", i), 32'(fault[i]), 32'd0);
      end
      reset = 1'b0;

      // Reset in the middle of a write aborts it with no done.
      @(negedge clock);
      start    = 1'b1;
      wr_req   = 1'b1;
      addr_in  = 16'h0030;
      wdata_in = 16'h7777;
      @(negedge clock);
      start  = 1'b0;
      wr_req = 1'b0;
      for (int i = 0; i < 2; i++)
         check($sformatf("abort_wren_hi%0d", i), 32'(mem_wren[i]), 32'd1);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("abort_wren%0d", i), 32'(mem_wren[i]), 32'd0);
         check($sformatf("abort_busy%0d", i), 32'(busy[i]), 32'd0);
         check($sformatf("abort_done%0d", i), 32'(done[i]), 32'd0);
         check($sformatf("abort_addr%0d", i), 32'(mem_addr[i]), 32'd0);
         check($sformatf("abort_wdata%0d", i), 32'(mem_wdata[i]), 32'd0);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++)
            check($sformatf("abort_no_done%0d", i), 32'(done[i]), 32'd0);
      end

      issue("wr10",     0, 1, 0, 16'h0010, 16'h1234, 16'h0000, 16'h0000, 0);
      issue("rd10",     1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 0);
      issue("rd05",     1, 0, 0, 16'h0005, 16'h0000, 16'h0000, 16'hBEEF, 0);
      issue("rdwr20",   1, 1, 0, 16'h0020, 16'hAAAA, 16'h0000, 16'h5A5A, 0);
      issue("rd20",     1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'h5A5A, 0);
      issue("nop_ext",  0, 0, 1, 16'h0000, 16'h0000, 16'h00FF, 16'h00FF, 1);
      issue("wr40_ext", 0, 1, 1, 16'h0040, 16'h4444, 16'h0F0F, 16'h0F0F, 0);
      issue("rd40_ext", 1, 0, 1, 16'h0040, 16'h0000, 16'h1111, 16'h1111, 0);
      issue("rd40",     1, 0, 0, 16'h0040, 16'h0000, 16'h1111, 16'h4444, 0);
      issue("nop",      0, 0, 0, 16'h0000, 16'h0000, 16'h2222, 16'h4444, 0);
      issue("rdfff",    1, 0, 0, 16'h0FFF, 16'h0000, 16'h0000, 16'hCAFE, 0);
      issue("wr1000",   0, 1, 0, 16'h1000, 16'h9999, 16'h0000, 16'hCAFE, 0);
      issue("rd10b",    1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 0);
`ifdef BOUND_CHECK_EN
      issue("rd1000",   1, 0, 0, 16'h1000, 16'h0000, 16'h0000, 16'h1234, 0);
`else
      issue("rd1000",   1, 0, 0, 16'h1000, 16'h0000, 16'h0000, 16'h9999, 0);
`endif

      repeat (4) @(negedge clock);
      check("sb_lat1_empty", sb0.size(), 0);
      check("sb_lat3_empty", sb1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
